// File: rtl/fadd_sub_sequencer_if.sv
// fadd_sub_sequencer_if: request, datapath-control and response bundle around the FP32 add/sub sequencer.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready on the response side.
interface fadd_sub_sequencer_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*32-1:0]    req_a;
  logic [NUM_REQ*32-1:0]    req_b;
  logic [NUM_REQ-1:0]       req_sub;
  logic [NUM_REQ*3-1:0]     req_rm;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic                     flush;

  logic [31:0]              dp_a;
  logic [31:0]              dp_b;
  logic                     dp_sub;
  logic [2:0]               dp_rm;
  logic                     en_align;
  logic                     en_add;
  logic                     en_norm;
  logic                     en_round;
  logic [31:0]              dp_result;
  logic [4:0]               dp_fflags;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [TAG_W-1:0]         rsp_tag;
  logic [31:0]              rsp_result;
  logic [4:0]               rsp_fflags;
  logic                     busy;

  // Environment side: requesters, datapath result, response consumer
  modport master (
    output req_valid, req_a, req_b, req_sub, req_rm, req_tag, flush,
    output dp_result, dp_fflags, rsp_ready,
    input  req_ready, dp_a, dp_b, dp_sub, dp_rm,
    input  en_align, en_add, en_norm, en_round,
    input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_fflags, busy
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_rm, req_tag, flush,
    input  dp_result, dp_fflags, rsp_ready,
    output req_ready, dp_a, dp_b, dp_sub, dp_rm,
    output en_align, en_add, en_norm, en_round,
    output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_fflags, busy
  );
endinterface

// File: rtl/fadd_sub_sequencer.sv
// fadd_sub_sequencer: round-robin shares one multicycle FP32 add/sub datapath between NUM_REQ requesters.
// Latency: accept at edge 0, stage enables in cycles 1..4, response valid from edge 5; issue interval >= 6.
// Backpressure: response held in RESP until rsp_ready; req_ready only in IDLE; flush drops the op.
module fadd_sub_sequencer #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  fadd_sub_sequencer_if.slave io_bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_cand;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_grant_found;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_en_align;
  logic               w_en_add;
  logic               w_en_norm;
  logic               w_en_round;
  logic               w_rsp_valid;

  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic               w_sel_sub;
  logic [2:0]         w_sel_rm;
  logic [TAG_W-1:0]   w_sel_tag;

  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_sub;
  logic [2:0]         r_rm;
  logic [TAG_W-1:0]   r_tag;
  logic [ID_W-1:0]    r_id;

  logic [31:0]        r_rsp_result;
  logic [4:0]         r_rsp_fflags;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [ID_W-1:0]    r_rsp_id;

  function automatic logic [ID_W-1:0] wrap_idx(input int unsigned v);
    return ID_W'(v % NUM_REQ);
  endfunction

  // Round-robin pick: first valid requester at or after the pointer, wrapping
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = wrap_idx(32'(r_ptr) + k);
      if (!w_grant_found && io_bus.req_valid[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  // Select the winning requester's operand fields
  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_sub = 1'b0;
    w_sel_rm  = '0;
    w_sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_W'(i)) begin
        w_sel_a   = io_bus.req_a[32*i +: 32];
        w_sel_b   = io_bus.req_b[32*i +: 32];
        w_sel_sub = io_bus.req_sub[i];
        w_sel_rm  = io_bus.req_rm[3*i +: 3];
        w_sel_tag = io_bus.req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  // Next state and per-state outputs; flush (and reset) silence every grant, enable and response
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_en_align  = 1'b0;
    w_en_add    = 1'b0;
    w_en_norm   = 1'b0;
    w_en_round  = 1'b0;
    w_rsp_valid = 1'b0;
    if (reset || io_bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_found) begin
            w_req_ready[w_grant_idx] = 1'b1;
            w_accept                 = 1'b1;
            w_state_nxt              = S_ALIGN;
          end
        end
        S_ALIGN: begin
          w_en_align  = 1'b1;
          w_state_nxt = S_ADD;
        end
        S_ADD: begin
          w_en_add    = 1'b1;
          w_state_nxt = S_NORM;
        end
        S_NORM: begin
          w_en_norm   = 1'b1;
          w_state_nxt = S_ROUND;
        end
        S_ROUND: begin
          w_en_round  = 1'b1;
          w_state_nxt = S_RESP;
        end
        S_RESP: begin
          // A flushed response is never offered, so a coincident rsp_ready cannot consume it
          w_rsp_valid = 1'b1;
          if (io_bus.rsp_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the winner's operands and move the pointer just past it on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sub <= 1'b0;
      r_rm  <= '0;
      r_tag <= '0;
      r_id  <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
      r_a   <= w_sel_a;
      r_b   <= w_sel_b;
      r_sub <= w_sel_sub;
      r_rm  <= w_sel_rm;
      r_tag <= w_sel_tag;
      r_id  <= w_grant_idx;
    end
  end

  // Capture the datapath result in ROUND; a flush discards whatever is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_result <= '0;
      r_rsp_fflags <= '0;
      r_rsp_tag    <= '0;
      r_rsp_id     <= '0;
    end else if (io_bus.flush) begin
      r_rsp_result <= '0;
      r_rsp_fflags <= '0;
      r_rsp_tag    <= '0;
      r_rsp_id     <= '0;
    end else if (r_state == S_ROUND) begin
      r_rsp_result <= io_bus.dp_result;
      r_rsp_fflags <= io_bus.dp_fflags;
      r_rsp_tag    <= r_tag;
      r_rsp_id     <= r_id;
    end
  end

  assign io_bus.req_ready  = w_req_ready;
  assign io_bus.dp_a       = r_a;
  assign io_bus.dp_b       = r_b;
  assign io_bus.dp_sub     = r_sub;
  assign io_bus.dp_rm      = r_rm;
  assign io_bus.en_align   = w_en_align;
  assign io_bus.en_add     = w_en_add;
  assign io_bus.en_norm    = w_en_norm;
  assign io_bus.en_round   = w_en_round;
  assign io_bus.rsp_valid  = w_rsp_valid;
  assign io_bus.rsp_id     = r_rsp_id;
  assign io_bus.rsp_tag    = r_rsp_tag;
  assign io_bus.rsp_result = r_rsp_result;
  assign io_bus.rsp_fflags = r_rsp_fflags;
  assign io_bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_fadd_sub_sequencer.sv
// tb_fadd_sub_sequencer: scoreboard bench for the FP32 add/sub sequencer.
// Latency: a transaction-level model predicts grants, stage enables and responses cycle by cycle.
// Backpressure: rsp_ready stalls and flush pulses are driven both directed and at random.
module tb_fadd_sub_sequencer;
  localparam int NR = 2;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fadd_sub_sequencer_if #(.NUM_REQ(NR), .TAG_W(TW)) ifc();

  fadd_sub_sequencer #(.NUM_REQ(NR), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(ifc)
  );

  typedef struct packed {
    logic [0:0]    id;
    logic [TW-1:0] tag;
    logic [31:0]   res;
    logic [4:0]    fl;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  // Transaction model: stage 0 idle, 1..4 align..round, 5 response pending
  int          m_stage   = 0;
  int          m_ptr     = 0;
  int          m_granted = -1;
  logic [31:0] m_a, m_b;
  logic        m_sub;
  logic [2:0]  m_rm;
  bit          auto_reload = 0;
  bit          rand_mode   = 0;
  logic [31:0] noise_r     = 32'h0;

  // Stand-in datapath: exact for the directed FP cases, an operand hash otherwise
  function automatic logic [36:0] fp_stub(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic [2:0] rm);
    if (!sub && a == 32'h3F800000 && b == 32'h40000000) return {5'b0, 32'h40400000};
    if (sub && a == b && a[30:23] != 8'hFF) return {5'b0, (rm == 3'b010) ? 32'h80000000 : 32'h0};
    return {a[4:0] ^ b[9:5] ^ {4'b0, sub}, a ^ {b[15:0], b[31:16]} ^ {29'b0, rm}};
  endfunction

  // Result is only meaningful during the round enable; noise elsewhere exposes mistimed capture
  always @(posedge clk) noise_r <= $urandom;
  assign {ifc.dp_fflags, ifc.dp_result} = ifc.en_round ?
      fp_stub(ifc.dp_a, ifc.dp_b, ifc.dp_sub, ifc.dp_rm) : {noise_r[4:0], noise_r};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic int winner();
    int j;
    for (int k = 0; k < NR; k++) begin
      j = (m_ptr + k) % NR;
      if (ifc.req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [2:0] rm, input logic [TW-1:0] tag);
    ifc.req_a[32*i +: 32]  = a;
    ifc.req_b[32*i +: 32]  = b;
    ifc.req_sub[i]         = sub;
    ifc.req_rm[3*i +: 3]   = rm;
    ifc.req_tag[TW*i +: TW] = tag;
    ifc.req_valid[i]       = 1'b1;
  endtask

  task automatic load_rand(input int i);
    logic [31:0] a;
    a = $urandom;
    set_req(i, a, ($urandom_range(0, 3) == 0) ? a : $urandom, 1'($urandom),
            3'($urandom_range(0, 4)), TW'($urandom));
  endtask

  task automatic random_drive();
    for (int i = 0; i < NR; i++) begin
      if (!ifc.req_valid[i] && $urandom_range(0, 2) == 0) load_rand(i);
      else if (ifc.req_valid[i] && $urandom_range(0, 19) == 0) ifc.req_valid[i] = 1'b0;
    end
    ifc.rsp_ready = ($urandom_range(0, 3) != 0);
    ifc.flush     = ($urandom_range(0, 49) == 0);
  endtask

  // Compare combinational outputs against the model's view of the current cycle
  task automatic check_outputs();
    logic [NR-1:0] rdy;
    logic [3:0]    en;
    int            w;
    rdy = '0;
    en  = '0;
    if (!reset && !ifc.flush) begin
      if (m_stage == 0) begin
        w = winner();
        if (w >= 0) rdy[w] = 1'b1;
      end else if (m_stage <= 4) begin
        en = 4'b1000 >> (m_stage - 1);
      end
    end
    chk("req_ready", 64'(ifc.req_ready), 64'(rdy));
    chk("en_onehot", 64'({ifc.en_align, ifc.en_add, ifc.en_norm, ifc.en_round}), 64'(en));
    chk("rsp_valid", 64'(ifc.rsp_valid), 64'(!reset && !ifc.flush && m_stage == 5));
    chk("busy", 64'(ifc.busy), 64'(m_stage != 0));
    if (m_stage >= 1 && m_stage <= 5) begin
      chk("dp_a", 64'(ifc.dp_a), 64'(m_a));
      chk("dp_b_sub_rm", 64'({ifc.dp_b, ifc.dp_sub, ifc.dp_rm}), 64'({m_b, m_sub, m_rm}));
    end
  endtask

  task automatic model_update();
    int   w;
    rsp_t e;
    logic [36:0] r;
    m_granted = -1;
    if (ifc.flush) begin
      if (m_stage != 0 && exp_q.size() > 0) void'(exp_q.pop_front());
      m_stage = 0;
    end else if (m_stage == 0) begin
      w = winner();
      if (w >= 0) begin
        m_a   = ifc.req_a[32*w +: 32];
        m_b   = ifc.req_b[32*w +: 32];
        m_sub = ifc.req_sub[w];
        m_rm  = ifc.req_rm[3*w +: 3];
        r     = fp_stub(m_a, m_b, m_sub, m_rm);
        e.id  = 1'(w);
        e.tag = ifc.req_tag[TW*w +: TW];
        e.res = r[31:0];
        e.fl  = r[36:32];
        exp_q.push_back(e);
        m_ptr     = (w + 1) % NR;
        m_stage   = 1;
        m_granted = w;
      end
    end else if (m_stage < 5) begin
      m_stage++;
    end else if (ifc.rsp_ready) begin
      m_stage = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    if (m_granted >= 0) begin
      if (auto_reload) load_rand(m_granted);
      else ifc.req_valid[m_granted] = 1'b0;
    end
    if (rand_mode) random_drive();
  endtask

  task automatic wait_stage(input int s, input int budget);
    int n;
    n = 0;
    while (m_stage != s && n < budget) begin
      cycle();
      n++;
    end
    if (m_stage != s) chk("wait_timeout", 64'(m_stage), 64'(s));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 64'({ifc.req_ready, ifc.en_align, ifc.en_add, ifc.en_norm, ifc.en_round,
                           ifc.rsp_valid, ifc.busy}), 64'(0));
    chk({nm, "_dp"}, 64'({ifc.dp_a, ifc.dp_b}), 64'(0));
    chk({nm, "_rsp"}, 64'({ifc.dp_sub, ifc.dp_rm, ifc.rsp_id, ifc.rsp_tag, ifc.rsp_fflags,
                           ifc.rsp_result}), 64'(0));
  endtask

  // Scoreboard monitor: every offered response must match the oldest expectation
  always @(negedge clk) begin
    rsp_t got;
    if (!reset && ifc.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(ifc.rsp_valid), 64'(0));
      end else begin
        got = {ifc.rsp_id, ifc.rsp_tag, ifc.rsp_result, ifc.rsp_fflags};
        chk("rsp_fields", 64'(got), 64'(exp_q[0]));
        if (ifc.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset         = 1'b1;
    ifc.req_valid = '0;
    ifc.req_a     = '0;
    ifc.req_b     = '0;
    ifc.req_sub   = '0;
    ifc.req_rm    = '0;
    ifc.req_tag   = '0;
    ifc.flush     = 1'b0;
    ifc.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_state");
    reset = 1'b0;

    // 1.0 + 2.0 from requester 0, tag 3
    ifc.rsp_ready = 1'b1;
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0, 3'b000, 5'd3);
    repeat (8) cycle();

    // Both requesters continuously valid: grants alternate
    auto_reload = 1;
    load_rand(0);
    load_rand(1);
    repeat (26) cycle();
    auto_reload   = 0;
    ifc.req_valid = '0;
    repeat (8) cycle();

    // Consumer stalls three cycles in RESP
    ifc.rsp_ready = 1'b0;
    load_rand(1);
    wait_stage(5, 20);
    repeat (3) cycle();
    ifc.rsp_ready = 1'b1;
    repeat (3) cycle();

    // Flush in NORM, then 1.0 - 1.0 from requester 1
    load_rand(0);
    wait_stage(3, 20);
    ifc.flush = 1'b1;
    cycle();
    ifc.flush = 1'b0;
    repeat (3) cycle();
    set_req(1, 32'h3F800000, 32'h3F800000, 1'b1, 3'b000, 5'd9);
    repeat (8) cycle();

    // Asynchronous reset during ADD; req0 wins first afterwards
    load_rand(0);
    wait_stage(2, 20);
    load_rand(1);
    #3;
    reset   = 1'b1;
    m_stage = 0;
    m_ptr   = 0;
    exp_q.delete();
    #1;
    chk_zero("reset_mid_op");
    @(posedge clk);
    #1;
    reset = 1'b0;
    load_rand(0);
    repeat (16) cycle();

    // Flush together with rsp_ready in RESP: response dropped, never reissued
    ifc.rsp_ready = 1'b0;
    load_rand(0);
    wait_stage(5, 20);
    ifc.flush     = 1'b1;
    ifc.rsp_ready = 1'b1;
    cycle();
    ifc.flush = 1'b0;
    repeat (8) cycle();

    // Randomised traffic with stalls, drops and flushes
    rand_mode = 1;
    repeat (3000) cycle();
    rand_mode     = 0;
    ifc.req_valid = '0;
    ifc.flush     = 1'b0;
    ifc.rsp_ready = 1'b1;
    repeat (10) cycle();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
